// File: rtl/econet_rx_queue.sv
// Econet multi-frame receive queue: circular byte buffer read as 32-bit words,
// plus a descriptor FIFO recording each committed frame.
module econet_rx_queue #(
  parameter int          BUF_BYTES  = 512,
  parameter int          CNT_WIDTH  = 9,
  parameter int          DESC_DEPTH = 4,
  parameter int          DESC_AW    = 2,
  parameter logic [15:0] FCS_GOOD   = 16'hF0B8,
  parameter bit          CHECK_FCS  = 1'b1
) (
  input  logic                 sys_clk,
  input  logic                 reset,
  input  logic [7:0]           rx_byte,
  input  logic                 rx_byte_ready,
  input  logic                 rx_frame_start,
  input  logic                 rx_frame_end,
  input  logic [15:0]          rx_fcs,
  input  logic                 sys_select,
  input  logic                 sys_rd,
  input  logic [CNT_WIDTH-3:0] sys_addr,
  input  logic                 desc_pop,
  output logic [31:0]          sys_data,
  output logic                 desc_valid,
  output logic [CNT_WIDTH-1:0] desc_start,
  output logic [CNT_WIDTH:0]   desc_len,
  output logic [DESC_AW:0]     desc_count,
  output logic [7:0]           err_fcs_cnt,
  output logic [7:0]           err_ovf_cnt
);

  localparam int WORDS = BUF_BYTES / 4;
  localparam logic [CNT_WIDTH:0] FULL = (CNT_WIDTH+1)'(BUF_BYTES);
  localparam logic [CNT_WIDTH:0] MIN_LEN = (CNT_WIDTH+1)'(2);
  localparam logic [DESC_AW:0] SLOTS = (DESC_AW+1)'(DESC_DEPTH);

  typedef enum logic [1:0] {IDLE, RECV, DISCARD} state_t;

  state_t state, state_n;

  logic [CNT_WIDTH:0] wr_ptr, cm_ptr, rd_ptr;
  logic [CNT_WIDTH:0] wr_n, cm_n, used, len;

  logic [31:0] mem [WORDS];

  logic [CNT_WIDTH-1:0] fifo_start [DESC_DEPTH];
  logic [CNT_WIDTH:0]   fifo_len [DESC_DEPTH];
  logic [DESC_AW-1:0]   desc_wp, desc_rp;

  logic wr_en, push, pop, inc_fcs, inc_ovf, fcs_ok;

  assign used = wr_ptr - rd_ptr;
  assign fcs_ok = (rx_fcs == FCS_GOOD) || !CHECK_FCS;
  assign pop = sys_select && desc_pop && desc_valid;

  assign desc_valid = (desc_count != '0);
  assign desc_start = fifo_start[desc_rp];
  assign desc_len = fifo_len[desc_rp];

  // Order within a cycle: byte, then frame end, then frame start.
  always_comb begin
    state_n = state;
    wr_n = wr_ptr;
    cm_n = cm_ptr;
    wr_en = 1'b0;
    push = 1'b0;
    inc_fcs = 1'b0;
    inc_ovf = 1'b0;
    len = wr_ptr - cm_ptr;
    if (state == RECV) begin
      if (rx_byte_ready) begin
        if (used == FULL) begin
          state_n = DISCARD;
          wr_n = cm_ptr;
          inc_ovf = 1'b1;
        end else begin
          wr_en = 1'b1;
          wr_n = wr_ptr + 1'b1;
        end
      end
      len = wr_n - cm_ptr;
      if (rx_frame_end) begin
        if (state_n == RECV) begin
          if (!fcs_ok || len < MIN_LEN) begin
            wr_n = cm_ptr;
            inc_fcs = 1'b1;
          end else if (desc_count == SLOTS) begin
            wr_n = cm_ptr;
            inc_ovf = 1'b1;
          end else begin
            push = 1'b1;
            cm_n = wr_n;
          end
        end
        state_n = IDLE;
      end
    end else if (state == DISCARD && rx_frame_end) begin
      state_n = IDLE;
    end
    if (rx_frame_start) begin
      state_n = RECV;
      wr_n = cm_n;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (wr_en)
      mem[wr_ptr[CNT_WIDTH-1:2]][{wr_ptr[1:0], 3'b000} +: 8] <= rx_byte;
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      wr_ptr <= '0;
      cm_ptr <= '0;
      rd_ptr <= '0;
      desc_wp <= '0;
      desc_rp <= '0;
      desc_count <= '0;
      err_fcs_cnt <= '0;
      err_ovf_cnt <= '0;
      sys_data <= '0;
      for (int i = 0; i < DESC_DEPTH; i++) begin
        fifo_start[i] <= '0;
        fifo_len[i] <= '0;
      end
    end else begin
      state <= state_n;
      wr_ptr <= wr_n;
      cm_ptr <= cm_n;
      if (push) begin
        fifo_start[desc_wp] <= cm_ptr[CNT_WIDTH-1:0];
        fifo_len[desc_wp] <= len;
        desc_wp <= desc_wp + 1'b1;
      end
      // Frames are contiguous, so the head start always equals rd_ptr.
      if (pop) begin
        rd_ptr <= rd_ptr + fifo_len[desc_rp];
        desc_rp <= desc_rp + 1'b1;
      end
      unique case ({push, pop})
        2'b10: desc_count <= desc_count + 1'b1;
        2'b01: desc_count <= desc_count - 1'b1;
        default: ;
      endcase
      if (inc_fcs && err_fcs_cnt != 8'hFF)
        err_fcs_cnt <= err_fcs_cnt + 1'b1;
      if (inc_ovf && err_ovf_cnt != 8'hFF)
        err_ovf_cnt <= err_ovf_cnt + 1'b1;
      if (sys_select && sys_rd)
        sys_data <= mem[sys_addr];
    end
  end

endmodule

// File: tb/tb_econet_rx_queue.sv
// Bench for econet_rx_queue: directed scenarios plus randomized traffic
// compared against a frame/queue-level reference model.
module tb_econet_rx_queue;

  localparam int BUF = 512;
  localparam int DEPTH = 4;
  localparam logic [15:0] GOOD = 16'hF0B8;

  logic        sys_clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_byte;
  logic        rx_byte_ready;
  logic        rx_frame_start;
  logic        rx_frame_end;
  logic [15:0] rx_fcs;
  logic        sys_select;
  logic        sys_rd;
  logic [6:0]  sys_addr;
  logic        desc_pop;
  logic [31:0] sys_data;
  logic        desc_valid;
  logic [8:0]  desc_start;
  logic [9:0]  desc_len;
  logic [2:0]  desc_count;
  logic [7:0]  err_fcs_cnt;
  logic [7:0]  err_ovf_cnt;

  econet_rx_queue dut (
    .sys_clk(sys_clk),
    .reset(reset),
    .rx_byte(rx_byte),
    .rx_byte_ready(rx_byte_ready),
    .rx_frame_start(rx_frame_start),
    .rx_frame_end(rx_frame_end),
    .rx_fcs(rx_fcs),
    .sys_select(sys_select),
    .sys_rd(sys_rd),
    .sys_addr(sys_addr),
    .desc_pop(desc_pop),
    .sys_data(sys_data),
    .desc_valid(desc_valid),
    .desc_start(desc_start),
    .desc_len(desc_len),
    .desc_count(desc_count),
    .err_fcs_cnt(err_fcs_cnt),
    .err_ovf_cnt(err_ovf_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;

  // Reference model: frames as byte lists, committed frames as a queue.
  typedef struct { int start; int len; } desc_t;
  desc_t       q[$];
  byte unsigned mbuf[BUF];
  byte unsigned cur[$];
  bit          m_in, m_disc;
  int          m_next, m_fcs, m_ovf;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int pend();
    int s = 0;
    foreach (q[i]) s += q[i].len;
    return s;
  endfunction

  function automatic bit in_pending(int a);
    foreach (q[i])
      if (((a - q[i].start + BUF) % BUF) < q[i].len) return 1'b1;
    return 1'b0;
  endfunction

  task automatic m_reset();
    q.delete();
    cur.delete();
    m_in = 0;
    m_disc = 0;
    m_next = 0;
    m_fcs = 0;
    m_ovf = 0;
  endtask

  task automatic m_byte(byte unsigned b);
    if (m_in && !m_disc) begin
      if (pend() + cur.size() == BUF) begin
        m_disc = 1;
        cur.delete();
        if (m_ovf < 255) m_ovf++;
      end else begin
        cur.push_back(b);
      end
    end
  endtask

  task automatic m_end(logic [15:0] fcs);
    desc_t d;
    if (m_in) begin
      if (!m_disc) begin
        if (fcs != GOOD || cur.size() < 2) begin
          if (m_fcs < 255) m_fcs++;
        end else if (q.size() == DEPTH) begin
          if (m_ovf < 255) m_ovf++;
        end else begin
          d.start = m_next;
          d.len = cur.size();
          q.push_back(d);
          foreach (cur[i]) mbuf[(m_next + i) % BUF] = cur[i];
          m_next = (m_next + d.len) % BUF;
        end
      end
      m_in = 0;
      m_disc = 0;
      cur.delete();
    end
  endtask

  task automatic m_start();
    m_in = 1;
    m_disc = 0;
    cur.delete();
  endtask

  task automatic idle_inputs();
    rx_byte = '0;
    rx_byte_ready = 0;
    rx_frame_start = 0;
    rx_frame_end = 0;
    rx_fcs = '0;
    sys_select = 0;
    sys_rd = 0;
    sys_addr = '0;
    desc_pop = 0;
  endtask

  task automatic cycle(bit st, bit by, logic [7:0] b, bit en,
                       logic [15:0] fcs, bit pop);
    bit vpre;
    desc_t dummy;
    rx_frame_start = st;
    rx_byte_ready = by;
    rx_byte = b;
    rx_frame_end = en;
    rx_fcs = fcs;
    desc_pop = pop;
    sys_select = pop;
    vpre = (q.size() != 0);
    if (by) m_byte(b);
    if (en) m_end(fcs);
    if (st) m_start();
    if (pop && vpre) dummy = q.pop_front();
    @(posedge sys_clk);
    #1;
    idle_inputs();
  endtask

  task automatic send(int n, logic [15:0] fcs, bit merge, bit pop_end,
                      bit seq);
    logic [7:0] b;
    bit last;
    cycle(1, 0, 8'h00, 0, 16'h0, 0);
    for (int i = 0; i < n; i++) begin
      b = seq ? 8'(i + 1) : 8'($urandom_range(0, 255));
      last = (i == n - 1);
      cycle(0, 1, b, merge && last, fcs, merge && last && pop_end);
    end
    if (!(merge && n > 0)) cycle(0, 0, 8'h00, 1, fcs, pop_end);
  endtask

  task automatic pop1();
    cycle(0, 0, 8'h00, 0, 16'h0, 1);
  endtask

  task automatic check_desc();
    chk("desc_count", 32'(desc_count), 32'(q.size()));
    chk("desc_valid", 32'(desc_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      chk("desc_start", 32'(desc_start), 32'(q[0].start));
      chk("desc_len", 32'(desc_len), 32'(q[0].len));
    end
    chk("err_fcs_cnt", 32'(err_fcs_cnt), 32'(m_fcs));
    chk("err_ovf_cnt", 32'(err_ovf_cnt), 32'(m_ovf));
  endtask

  task automatic read_word(int w);
    logic [31:0] exp, mask;
    sys_select = 1;
    sys_rd = 1;
    sys_addr = 7'(w);
    @(posedge sys_clk);
    #1;
    idle_inputs();
    exp = '0;
    mask = '0;
    for (int l = 0; l < 4; l++) begin
      if (in_pending(w * 4 + l)) begin
        exp[l*8 +: 8] = mbuf[w * 4 + l];
        mask[l*8 +: 8] = 8'hFF;
      end
    end
    if (mask != 0) chk($sformatf("word%0d", w), sys_data & mask, exp & mask);
  endtask

  task automatic reset_dut();
    idle_inputs();
    reset = 1;
    repeat (2) @(posedge sys_clk);
    #1;
    reset = 0;
    m_reset();
  endtask

  task automatic check_zero(string tag);
    chk({tag, "_data"}, sys_data, 32'h0);
    chk({tag, "_valid"}, 32'(desc_valid), 32'h0);
    chk({tag, "_start"}, 32'(desc_start), 32'h0);
    chk({tag, "_len"}, 32'(desc_len), 32'h0);
    chk({tag, "_count"}, 32'(desc_count), 32'h0);
    chk({tag, "_fcs"}, 32'(err_fcs_cnt), 32'h0);
    chk({tag, "_ovf"}, 32'(err_ovf_cnt), 32'h0);
  endtask

  initial begin
    int op, n, k, a;
    idle_inputs();
    m_reset();
    reset_dut();
    check_zero("reset");

    // Single 6-byte frame with known content.
    send(6, GOOD, 0, 0, 1);
    check_desc();
    chk("first_len", 32'(desc_len), 32'd6);
    read_word(0);
    chk("word0_lit", sys_data, 32'h04030201);
    read_word(1);
    chk("word1_lit", sys_data & 32'h0000FFFF, 32'h00000605);

    // Three 100-byte frames retire in order.
    reset_dut();
    repeat (3) send(100, GOOD, 0, 0, 0);
    check_desc();
    chk("three_count", 32'(desc_count), 32'd3);
    for (int i = 0; i < 3; i++) begin
      chk("three_start", 32'(desc_start), 32'(i * 100));
      pop1();
      check_desc();
    end

    // Bad FCS then a good frame reuses offset 0.
    reset_dut();
    send(30, 16'h1234, 0, 0, 0);
    check_desc();
    chk("badfcs_cnt", 32'(err_fcs_cnt), 32'd1);
    send(30, GOOD, 0, 0, 0);
    check_desc();
    chk("after_bad_start", 32'(desc_start), 32'd0);

    // Buffer overflow, then a resend that wraps the buffer.
    reset_dut();
    send(200, GOOD, 0, 0, 0);
    send(200, GOOD, 0, 0, 0);
    send(200, GOOD, 0, 0, 0);
    check_desc();
    chk("ovf_cnt", 32'(err_ovf_cnt), 32'd1);
    pop1();
    send(200, GOOD, 0, 0, 0);
    check_desc();
    pop1();
    check_desc();
    chk("wrap_start", 32'(desc_start), 32'd400);
    chk("wrap_len", 32'(desc_len), 32'd200);
    for (int w = 120; w < 128; w++) read_word(w);
    for (int w = 0; w < 23; w++) read_word(w);

    // FIFO full with byte+end merged in the same cycle.
    reset_dut();
    repeat (5) send(10, GOOD, 1, 0, 0);
    check_desc();
    chk("fifo_full_ovf", 32'(err_ovf_cnt), 32'd1);
    chk("merged_len", 32'(desc_len), 32'd10);
    pop1();
    send(8, GOOD, 1, 1, 0);
    check_desc();
    chk("push_pop_count", 32'(desc_count), 32'd3);

    // Short frames, and a restart that abandons a partial frame.
    send(1, GOOD, 0, 0, 0);
    send(0, GOOD, 0, 0, 0);
    check_desc();
    cycle(1, 0, 8'h00, 0, 16'h0, 0);
    for (int i = 0; i < 20; i++) cycle(0, 1, 8'($urandom), 0, 16'h0, 0);
    send(12, GOOD, 0, 0, 0);
    check_desc();

    // Randomized traffic.
    reset_dut();
    for (int it = 0; it < 80; it++) begin
      op = int'($urandom_range(0, 9));
      if (op <= 5) begin
        n = int'($urandom_range(0, 160));
        send(n, ($urandom_range(0, 4) != 0) ? GOOD : 16'($urandom),
             1'($urandom), $urandom_range(0, 3) == 0, 0);
      end else if (op <= 7) begin
        pop1();
      end else if (q.size() != 0) begin
        k = int'($urandom_range(0, q.size() - 1));
        a = (q[k].start + int'($urandom_range(0, q[k].len - 1))) % BUF;
        read_word(a / 4);
      end
      check_desc();
    end

    // Error counter saturation.
    repeat (260) send(0, GOOD, 0, 0, 0);
    check_desc();
    chk("fcs_sat", 32'(err_fcs_cnt), 32'hFF);

    // Reset in the middle of a frame.
    reset_dut();
    send(20, GOOD, 0, 0, 0);
    read_word(0);
    cycle(1, 0, 8'h00, 0, 16'h0, 0);
    for (int i = 0; i < 50; i++) cycle(0, 1, 8'($urandom), 0, 16'h0, 0);
    reset = 1;
    #2;
    check_zero("midrst");
    @(posedge sys_clk);
    #1;
    reset = 0;
    m_reset();
    send(10, GOOD, 0, 0, 0);
    check_desc();
    chk("post_rst_start", 32'(desc_start), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
